// File: rtl/pmu_lpmd_fsm.sv
// PMU low-power sequencer: gates the core clock after a stable low-power request and
// restores it after a wake event plus a stabilisation window. Optional wake counter: PMU_LPMD_WAKE_CNT_EN.
module pmu_lpmd_fsm #(
    parameter int unsigned ENTRY_CYC  = 4,
    parameter int unsigned STABLE_CYC = 8
) (
    input  logic        fast_clk,
    input  logic        pad_cpu_rst_b,
    input  logic [1:0]  cpu_pmu_lpmd_b,
    input  logic        wake_evt,
    output logic        pmu_clk_en,
    output logic        pmu_sleep_st,
    output logic        pmu_wake_ack,
    output logic [1:0]  pmu_state,
    output logic [15:0] pmu_wake_cnt
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_ENTRY = 2'b01,
        ST_SLEEP = 2'b10,
        ST_EXIT  = 2'b11
    } state_t;

    localparam logic [7:0] ENTRY_LOAD  = 8'(ENTRY_CYC - 1);
    localparam logic [7:0] STABLE_LOAD = 8'(STABLE_CYC - 1);

    state_t      state_r;
    state_t      state_s;
    logic [7:0]  cnt_r;
    logic [7:0]  cnt_s;
    logic        armed_r;
    logic        armed_s;
    logic        wake_ack_s;
    logic        lpmd_req_s;
    logic        clk_en_r;
    logic        sleep_st_r;
    logic        wake_ack_r;

    assign lpmd_req_s = (cpu_pmu_lpmd_b != 2'b11);

    // Next-state, counter and re-arm logic
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        armed_s    = armed_r;
        wake_ack_s = 1'b0;
        case (state_r)
            ST_RUN: begin
                // The core cannot drop its request while gated, so re-entry waits for one deassertion.
                if (!lpmd_req_s) begin
                    armed_s = 1'b1;
                end else begin
                    armed_s = armed_r;
                end
                if (lpmd_req_s && armed_r && !wake_evt) begin
                    state_s = ST_ENTRY;
                    cnt_s   = ENTRY_LOAD;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_ENTRY: begin
                if (!lpmd_req_s || wake_evt) begin
                    state_s = ST_RUN;
                    cnt_s   = 8'd0;
                end else if (cnt_r == 8'd0) begin
                    state_s = ST_SLEEP;
                end else begin
                    cnt_s = cnt_r - 8'd1;
                end
            end
            ST_SLEEP: begin
                if (wake_evt) begin
                    state_s = ST_EXIT;
                    cnt_s   = STABLE_LOAD;
                end else begin
                    state_s = ST_SLEEP;
                end
            end
            ST_EXIT: begin
                if (cnt_r == 8'd0) begin
                    state_s    = ST_RUN;
                    wake_ack_s = 1'b1;
                    armed_s    = 1'b0;
                end else begin
                    cnt_s = cnt_r - 8'd1;
                end
            end
            default: begin
                state_s = ST_RUN;
                cnt_s   = 8'd0;
            end
        endcase
    end

    // State, counter and registered output flops
    always_ff @(posedge fast_clk or negedge pad_cpu_rst_b) begin
        if (!pad_cpu_rst_b) begin
            state_r    <= ST_RUN;
            cnt_r      <= 8'd0;
            armed_r    <= 1'b1;
            clk_en_r   <= 1'b1;
            sleep_st_r <= 1'b0;
            wake_ack_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            armed_r    <= armed_s;
            clk_en_r   <= (state_s != ST_SLEEP);
            sleep_st_r <= (state_s == ST_SLEEP);
            wake_ack_r <= wake_ack_s;
        end
    end

    assign pmu_clk_en   = clk_en_r;
    assign pmu_sleep_st = sleep_st_r;
    assign pmu_wake_ack = wake_ack_r;
    assign pmu_state    = state_r;

`ifdef PMU_LPMD_WAKE_CNT_EN
    logic [15:0] wake_cnt_r;
    logic        wake_inc_s;

    assign wake_inc_s = (state_r == ST_SLEEP) && (state_s == ST_EXIT);

    // Saturating count of SLEEP->EXIT transitions, cleared only by reset
    always_ff @(posedge fast_clk or negedge pad_cpu_rst_b) begin
        if (!pad_cpu_rst_b) begin
            wake_cnt_r <= 16'h0000;
        end else if (wake_inc_s && (wake_cnt_r != 16'hFFFF)) begin
            wake_cnt_r <= wake_cnt_r + 16'd1;
        end else begin
            wake_cnt_r <= wake_cnt_r;
        end
    end

    assign pmu_wake_cnt = wake_cnt_r;
`else
    assign pmu_wake_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pmu_lpmd_fsm.sv
// Table-driven bench for pmu_lpmd_fsm (ENTRY_CYC=4, STABLE_CYC=8) plus hand-written
// sequences for async reset in SLEEP and the optional PMU_LPMD_WAKE_CNT_EN counter.
module tb_pmu_lpmd_fsm;

    localparam int ENTRY_CYC  = 4;
    localparam int STABLE_CYC = 8;

    logic        fast_clk;
    logic        pad_cpu_rst_b;
    logic [1:0]  cpu_pmu_lpmd_b;
    logic        wake_evt;
    logic        pmu_clk_en;
    logic        pmu_sleep_st;
    logic        pmu_wake_ack;
    logic [1:0]  pmu_state;
    logic [15:0] pmu_wake_cnt;

    int n_total;
    int n_pass;

    typedef struct {
        logic [1:0] lpmd_b;
        logic       wake;
        logic       clk_en;
        logic       sleep_st;
        logic       ack;
        logic [1:0] state;
    } vec_t;

    vec_t vecs[$];

    pmu_lpmd_fsm #(.ENTRY_CYC(ENTRY_CYC), .STABLE_CYC(STABLE_CYC)) dut (
        .fast_clk       (fast_clk),
        .pad_cpu_rst_b  (pad_cpu_rst_b),
        .cpu_pmu_lpmd_b (cpu_pmu_lpmd_b),
        .wake_evt       (wake_evt),
        .pmu_clk_en     (pmu_clk_en),
        .pmu_sleep_st   (pmu_sleep_st),
        .pmu_wake_ack   (pmu_wake_ack),
        .pmu_state      (pmu_state),
        .pmu_wake_cnt   (pmu_wake_cnt)
    );

    initial fast_clk = 1'b0;
    always #5 fast_clk = ~fast_clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge fast_clk);
        #1;
    endtask

    function automatic logic [15:0] outs();
        return {11'd0, pmu_clk_en, pmu_sleep_st, pmu_wake_ack, pmu_state};
    endfunction

    function automatic logic [15:0] pack(input logic c, input logic s, input logic a, input logic [1:0] st);
        return {11'd0, c, s, a, st};
    endfunction

    // One full sleep/wake round trip starting from RUN
    task automatic do_cycle(input int idx);
        cpu_pmu_lpmd_b = 2'b11;
        wake_evt       = 1'b0;
        step();
        cpu_pmu_lpmd_b = 2'b00;
        repeat (ENTRY_CYC) step();
        chk($sformatf("cyc%0d_entry", idx), outs(), pack(1'b1, 1'b0, 1'b0, 2'b01));
        step();
        chk($sformatf("cyc%0d_sleep", idx), outs(), pack(1'b0, 1'b1, 1'b0, 2'b10));
        wake_evt = 1'b1;
        step();
        chk($sformatf("cyc%0d_exit", idx), outs(), pack(1'b1, 1'b0, 1'b0, 2'b11));
        wake_evt = 1'b0;
        repeat (STABLE_CYC - 1) step();
        chk($sformatf("cyc%0d_preack", idx), outs(), pack(1'b1, 1'b0, 1'b0, 2'b11));
        step();
        chk($sformatf("cyc%0d_ack", idx), outs(), pack(1'b1, 1'b0, 1'b1, 2'b00));
    endtask

    initial begin
        logic [15:0] exp_wc;
        logic [1:0]  prev_state;
        n_total = 0;
        n_pass  = 0;

        // lpmd_b, wake -> clk_en, sleep_st, ack, state
        vecs.push_back('{2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00});  // 0 idle
        vecs.push_back('{2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01});  // 1 request -> ENTRY
        vecs.push_back('{2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01});
        vecs.push_back('{2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01});
        vecs.push_back('{2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01});
        vecs.push_back('{2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10});  // 5 gated at N+4
        vecs.push_back('{2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10});  // request ignored in SLEEP
        vecs.push_back('{2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11});  // 7 wake -> EXIT
        vecs.push_back('{2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11});
        vecs.push_back('{2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11});
        vecs.push_back('{2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11});
        vecs.push_back('{2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11});
        vecs.push_back('{2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11});
        vecs.push_back('{2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11});
        vecs.push_back('{2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11});
        vecs.push_back('{2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00});  // 15 ack at M+8
        vecs.push_back('{2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00});  // disarmed: stay RUN
        vecs.push_back('{2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00});
        vecs.push_back('{2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00});  // re-arm
        vecs.push_back('{2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01});  // re-enter ENTRY
        vecs.push_back('{2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00});  // abort on drop
        vecs.push_back('{2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01});
        vecs.push_back('{2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01});
        vecs.push_back('{2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00});  // abort after 2 cycles
        vecs.push_back('{2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01});
        vecs.push_back('{2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00});  // wake aborts ENTRY
        vecs.push_back('{2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00});  // wake has priority in RUN
        vecs.push_back('{2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01});  // still armed after abort
        vecs.push_back('{2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00});

        pad_cpu_rst_b  = 1'b0;
        cpu_pmu_lpmd_b = 2'b11;
        wake_evt       = 1'b0;
        step();
        step();
        chk("reset_outs", outs(), pack(1'b1, 1'b0, 1'b0, 2'b00));
        chk("reset_wake_cnt", pmu_wake_cnt, 16'h0000);
        pad_cpu_rst_b = 1'b1;

        for (int i = 0; i < 50; i++) begin
            step();
            chk($sformatf("idle%0d", i), outs(), pack(1'b1, 1'b0, 1'b0, 2'b00));
        end

        exp_wc     = 16'h0000;
        prev_state = 2'b00;
        for (int i = 0; i < vecs.size(); i++) begin
            cpu_pmu_lpmd_b = vecs[i].lpmd_b;
            wake_evt       = vecs[i].wake;
            step();
`ifdef PMU_LPMD_WAKE_CNT_EN
            if (prev_state == 2'b10 && vecs[i].state == 2'b11) begin
                exp_wc = exp_wc + 16'd1;
            end
`endif
            prev_state = vecs[i].state;
            chk($sformatf("vec%0d", i), outs(),
                pack(vecs[i].clk_en, vecs[i].sleep_st, vecs[i].ack, vecs[i].state));
            chk($sformatf("vec%0d_wcnt", i), pmu_wake_cnt, exp_wc);
        end

        // Asynchronous reset while gated
        cpu_pmu_lpmd_b = 2'b00;
        repeat (ENTRY_CYC + 1) step();
        chk("pre_rst_sleep", outs(), pack(1'b0, 1'b1, 1'b0, 2'b10));
        #2;
        pad_cpu_rst_b = 1'b0;
        #1;
        chk("async_rst_sleep", outs(), pack(1'b1, 1'b0, 1'b0, 2'b00));
        chk("async_rst_wcnt", pmu_wake_cnt, 16'h0000);
        step();
        cpu_pmu_lpmd_b = 2'b11;
        pad_cpu_rst_b  = 1'b1;
        step();
        chk("post_rst_run", outs(), pack(1'b1, 1'b0, 1'b0, 2'b00));

        for (int k = 0; k < 3; k++) begin
            do_cycle(k);
        end
`ifdef PMU_LPMD_WAKE_CNT_EN
        chk("wake_cnt_3", pmu_wake_cnt, 16'd3);
        #2;
        force dut.wake_cnt_r = 16'hFFFF;
        #1;
        release dut.wake_cnt_r;
        do_cycle(3);
        chk("wake_cnt_sat", pmu_wake_cnt, 16'hFFFF);
`else
        chk("wake_cnt_tied", pmu_wake_cnt, 16'h0000);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
